// File: rtl/fpgame_video_pkg.sv
// Shared video constants and types for the PPU scanout path: default 640x480@60
// timing, palette word layout and the RGB / sync bundle types.
package fpgame_video_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int PAL_R_LSB = 16;
    localparam int PAL_G_LSB = 8;
    localparam int PAL_B_LSB = 0;

    // Counter -> pins: row RAM read, palette RAM read, output register.
    localparam int SCANOUT_LAT = 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1};

    function automatic rgb_t pal_to_rgb(input logic [31:0] w);
        rgb_t c;
        c.r = w[PAL_R_LSB +: 8];
        c.g = w[PAL_G_LSB +: 8];
        c.b = w[PAL_B_LSB +: 8];
        return c;
    endfunction

endpackage

// File: rtl/video_timing.sv
// Raster counters for the scanout path: undelayed active/sync flags, the row
// hand-off strobe to the renderer and the frame-start strobe.
module video_timing
    import fpgame_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] h_next_o,
    output logic       active_o,
    output logic       hsync_raw_o,
    output logic       vsync_raw_o,
    output logic       line_req_o,
    output logic [7:0] line_num_o,
    output logic       frame_start_o
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] V_LVIS  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] H_SS    = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SS    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE    = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_q, h_d, v_q, v_d;
    logic       req_q, req_d;
    logic [7:0] num_q, num_d;
    logic       fs_q, fs_d;

    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
    end

    // Strobe is decoded from the next counter value so that the registered
    // pulse and its line_num land in the cycle where h_cnt == H_ACTIVE.
    always_comb begin
        req_d = (h_d == H_ACT) &&
                ((v_d[0] && (v_d < V_LVIS)) || (v_d == V_LAST));
        num_d = num_q;
        if (req_d) begin
            num_d = (v_d == V_LAST) ? 8'd0 : v_d[8:1] + 8'd1;
        end
        fs_d = (h_q == '0) && (v_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q   <= '0;
            v_q   <= '0;
            req_q <= 1'b0;
            num_q <= '0;
            fs_q  <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            req_q <= req_d;
            num_q <= num_d;
            fs_q  <= fs_d;
        end
    end

    assign h_next_o      = h_d;
    assign active_o      = (h_q < H_ACT) && (v_q < V_ACT);
    assign hsync_raw_o   = !((h_q >= H_SS) && (h_q < H_SE));
    assign vsync_raw_o   = !((v_q >= V_SS) && (v_q < V_SE));
    assign line_req_o    = req_q;
    assign line_num_o    = num_q;
    assign frame_start_o = fs_q;

endmodule

// File: rtl/video_scanout.sv
// Row RAM / palette RAM reader: fetches each source pixel twice per line,
// resolves it through the palette and drives registered RGB, sync and DE.
module video_scanout
    import fpgame_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [8:0]  rram_rdaddr,
    input  logic [9:0]  rram_rddata,
    output logic [9:0]  pram_rdaddr,
    input  logic [31:0] pram_rddata,
    output logic [7:0]  vid_r,
    output logic [7:0]  vid_g,
    output logic [7:0]  vid_b,
    output logic        vid_hsync,
    output logic        vid_vsync,
    output logic        vid_de,
    output logic        line_req,
    output logic [7:0]  line_num,
    output logic        frame_start
);

    logic [9:0] h_next;
    logic       active, hs_raw, vs_raw;

    video_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk          (clk),
        .rst_n        (rst_n),
        .h_next_o     (h_next),
        .active_o     (active),
        .hsync_raw_o  (hs_raw),
        .vsync_raw_o  (vs_raw),
        .line_req_o   (line_req),
        .line_num_o   (line_num),
        .frame_start_o(frame_start)
    );

    logic [8:0]                  rdaddr_q, rdaddr_d;
    sync_t                       raw;
    sync_t [SCANOUT_LAT-1:0]     pipe_q, pipe_d;
    rgb_t                        rgb_q, rgb_d;
    logic                        unused_alpha;

    // Address tracks the counter so it is valid in the same cycle; h/2 gives
    // the horizontal pixel doubling.
    assign rdaddr_d = (h_next < 10'(H_ACTIVE)) ? h_next[9:1] : '0;

    assign raw    = '{de: active, hs: hs_raw, vs: vs_raw};
    assign pipe_d = {pipe_q[SCANOUT_LAT-2:0], raw};

    // Stage SCANOUT_LAT-2 is the flag for the pixel whose palette word is on
    // pram_rddata right now.
    assign rgb_d = pipe_q[SCANOUT_LAT-2].de ? pal_to_rgb(pram_rddata) : '0;

    assign unused_alpha = ^pram_rddata[31:24];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdaddr_q <= '0;
            pipe_q   <= {SCANOUT_LAT{SYNC_IDLE}};
            rgb_q    <= '0;
        end else begin
            rdaddr_q <= rdaddr_d;
            pipe_q   <= pipe_d;
            rgb_q    <= rgb_d;
        end
    end

    assign rram_rdaddr = rdaddr_q;
    assign pram_rdaddr = rram_rddata;
    assign vid_r       = rgb_q.r;
    assign vid_g       = rgb_q.g;
    assign vid_b       = rgb_q.b;
    assign vid_de      = pipe_q[SCANOUT_LAT-1].de;
    assign vid_hsync   = pipe_q[SCANOUT_LAT-1].hs;
    assign vid_vsync   = pipe_q[SCANOUT_LAT-1].vs;

endmodule

// File: tb/tb_video_scanout.sv
// Scoreboard bench for video_scanout: full horizontal timing, shortened vertical
// timing so two whole frames plus a mid-frame reset fit in a short run.
module tb_video_scanout;

    localparam int HT    = 800;
    localparam int VA    = 8;
    localparam int VF    = 2;
    localparam int VS    = 2;
    localparam int VB    = 2;
    localparam int VT    = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  rram_rdaddr;
    logic [9:0]  rram_rddata = '0;
    logic [9:0]  pram_rdaddr;
    logic [31:0] pram_rddata = '0;
    logic [7:0]  vid_r, vid_g, vid_b;
    logic        vid_hsync, vid_vsync, vid_de;
    logic        line_req;
    logic [7:0]  line_num;
    logic        frame_start;

    video_scanout #(
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rram_rdaddr(rram_rdaddr), .rram_rddata(rram_rddata),
        .pram_rdaddr(pram_rdaddr), .pram_rddata(pram_rddata),
        .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
        .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .vid_de(vid_de),
        .line_req(line_req), .line_num(line_num), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    logic [9:0]  row_mem [0:511];
    logic [31:0] pal_mem [0:1023];

    always @(posedge clk) begin
        rram_rddata <= row_mem[rram_rdaddr];
        pram_rddata <= pal_mem[pram_rdaddr];
    end

    // n = raster index currently held by the DUT counters (sampled at negedge)
    int n;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (n=%0d)", nm, act, exp, n);
        end
    endtask

    typedef struct {
        int         v;
        logic [7:0] num;
    } req_t;

    logic [23:0] pix_q[$];
    req_t        req_q[$];
    int          fs_q[$];

    logic mon_en = 1'b0;
    logic chk_en = 1'b0;

    // Pixel monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (vid_de) begin
                if (pix_q.size() == 0) chk("pix_underflow", 32'd1, 32'd0);
                else chk("pix", {8'h0, vid_r, vid_g, vid_b}, {8'h0, pix_q.pop_front()});
            end else if (n >= 3 && (n - 3) % HT == 700) begin
                chk("blank_rgb", {8'h0, vid_r, vid_g, vid_b}, 32'd0);
            end
        end
    end

    // Strobe and sync-edge monitor
    logic prev_de = 1'b0, prev_hs = 1'b1, prev_vs = 1'b1;
    int de_rise_n, hs_fall_n, vs_fall_n;
    int de_rises = 0, hs_falls = 0, vs_falls = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (line_req) begin
                if (req_q.size() == 0) chk("req_extra", 32'd1, 32'd0);
                else begin
                    req_t r;
                    r = req_q.pop_front();
                    chk("req_h", n % HT, 640);
                    chk("req_v", (n / HT) % VT, r.v);
                    chk("req_num", {24'h0, line_num}, {24'h0, r.num});
                end
            end
            if (frame_start) begin
                if (fs_q.size() == 0) chk("fs_extra", 32'd1, 32'd0);
                else chk("fs_idx", n, fs_q.pop_front());
            end
            if (vid_de && !prev_de) begin
                de_rises++;
                de_rise_n = n;
                chk("de_rise_col", (n - 3) % HT, 0);
            end
            if (!vid_de && prev_de) chk("de_width", n - de_rise_n, 640);
            if (!vid_hsync && prev_hs) begin
                hs_falls++;
                hs_fall_n = n;
                chk("hs_fall_col", (n - 3) % HT, 656);
            end
            if (vid_hsync && !prev_hs) chk("hs_width", n - hs_fall_n, 96);
            if (!vid_vsync && prev_vs) begin
                vs_falls++;
                vs_fall_n = n;
                chk("vs_fall_col", (n - 3) % HT, 0);
                chk("vs_fall_line", ((n - 3) / HT) % VT, VA + VF);
            end
            if (vid_vsync && !prev_vs) chk("vs_width", n - vs_fall_n, VS * HT);
            prev_de = vid_de;
            prev_hs = vid_hsync;
            prev_vs = vid_vsync;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish (n=%0d)", n);
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_de"},    {31'h0, vid_de}, 32'd0);
        chk({tag, "_hs"},    {31'h0, vid_hsync}, 32'd1);
        chk({tag, "_vs"},    {31'h0, vid_vsync}, 32'd1);
        chk({tag, "_rgb"},   {8'h0, vid_r, vid_g, vid_b}, 32'd0);
        chk({tag, "_req"},   {31'h0, line_req}, 32'd0);
        chk({tag, "_addr"},  {23'h0, rram_rdaddr}, 32'd0);
        chk({tag, "_num"},   {24'h0, line_num}, 32'd0);
        chk({tag, "_fs"},    {31'h0, frame_start}, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] kb;
    logic       seen_req;

    initial begin
        for (int i = 0; i < 512; i++)  row_mem[i] = 10'($urandom);
        for (int i = 0; i < 1024; i++) pal_mem[i] = $urandom;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");

        // Line 0 sees row[0]=5 -> pal[5]=FF123456; everything else identity.
        for (int k = 0; k < 320; k++) begin
            kb = k[7:0];
            row_mem[k] = 10'(k);
            pal_mem[k] = {8'h00, kb, kb, kb};
        end
        row_mem[0] = 10'h005;
        pal_mem[5] = 32'hFF123456;

        for (int f = 0; f < 2; f++)
            for (int l = 0; l < VA; l++)
                for (int c = 0; c < 640; c++) begin
                    kb = 8'(c >> 1);
                    if (f == 0 && l == 0 && ((c >> 1) == 0 || (c >> 1) == 5))
                        pix_q.push_back(24'h123456);
                    else
                        pix_q.push_back({kb, kb, kb});
                end
        for (int f = 0; f < 2; f++) begin
            req_q.push_back('{v: 1,  num: 8'd1});
            req_q.push_back('{v: 3,  num: 8'd2});
            req_q.push_back('{v: 5,  num: 8'd3});
            req_q.push_back('{v: 13, num: 8'd0});
        end
        fs_q.push_back(1);
        fs_q.push_back(1 + FRAME);

        mon_en = 1'b1;
        chk_en = 1'b1;
        rst_n  = 1'b1;

        step();
        chk("first_fs", {31'h0, frame_start}, 32'd1);
        chk("first_de_n1", {31'h0, vid_de}, 32'd0);
        step();
        chk("first_de_n2", {31'h0, vid_de}, 32'd0);
        step();
        chk("first_de_n3", {31'h0, vid_de}, 32'd1);
        chk("first_rgb", {8'h0, vid_r, vid_g, vid_b}, 32'h123456);
        step();
        chk("first_rgb_dbl", {8'h0, vid_r, vid_g, vid_b}, 32'h123456);

        while (n < 700) @(negedge clk);
        row_mem[0] = 10'h000;
        pal_mem[5] = 32'h00050505;

        while (n < 2 * FRAME) @(negedge clk);
        mon_en = 1'b0;
        chk_en = 1'b0;
        chk("pix_left", pix_q.size(), 0);
        chk("req_left", req_q.size(), 0);
        chk("fs_left", fs_q.size(), 0);
        chk("de_rises", de_rises, 2 * VA);
        chk("hs_falls", hs_falls, 2 * VT);
        chk("vs_falls", vs_falls, 2);

        // Mid-frame reset at v=5, h=300 of the third frame
        while (n < 2 * FRAME + 5 * HT + 300) @(negedge clk);
        chk("mid_de_before", {31'h0, vid_de}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_req = 1'b0;
        step();
        chk("mid_fs", {31'h0, frame_start}, 32'd1);
        chk("mid_de_n1", {31'h0, vid_de}, 32'd0);
        step();
        chk("mid_fs_once", {31'h0, frame_start}, 32'd0);
        chk("mid_de_n2", {31'h0, vid_de}, 32'd0);
        step();
        chk("mid_de_n3", {31'h0, vid_de}, 32'd1);
        step();
        step();
        chk("mid_rgb_col2", {8'h0, vid_r, vid_g, vid_b}, 32'h010101);
        for (int i = 0; i < 20; i++) begin
            if (line_req) seen_req = 1'b1;
            step();
        end
        chk("mid_no_partial_req", {31'h0, seen_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
